// File: rtl/mouse_cursor_ctrl_if.sv
// Signal bundle between the PS/2 mouse interface side and the cursor controller.
// slave = the controller, master = whoever drives packets and watches the cursor.
`timescale 1ns/1ps
interface mouse_cursor_ctrl_if;
    logic       data_ready;
    logic [8:0] x_increment;
    logic [8:0] y_increment;
    logic       left_button;
    logic       right_button;
    logic       error_no_ack;
    logic       rearm;
    logic       mouse_reset;
    logic       mouse_read;
    logic [9:0] cursor_x;
    logic [9:0] cursor_y;
    logic       btn_left;
    logic       btn_right;
    logic       draw_valid;
    logic       link_up;
    logic       link_fail;

    modport slave (
        input  data_ready, x_increment, y_increment, left_button, right_button,
        input  error_no_ack, rearm,
        output mouse_reset, mouse_read, cursor_x, cursor_y, btn_left, btn_right,
        output draw_valid, link_up, link_fail
    );

    modport master (
        output data_ready, x_increment, y_increment, left_button, right_button,
        output error_no_ack, rearm,
        input  mouse_reset, mouse_read, cursor_x, cursor_y, btn_left, btn_right,
        input  draw_valid, link_up, link_fail
    );
endinterface

// File: rtl/mouse_cursor_ctrl.sv
// PS/2 link supervisor plus clamped cursor integrator; a packet sampled on one edge
// updates cursor/buttons/draw_valid on that edge, with data_ready ignored while mouse_read is high.
`timescale 1ns/1ps
module mouse_cursor_ctrl #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int SENS_SHIFT     = 0,
    parameter int ACK_TIMEOUT    = 27000,
    parameter int BACKOFF_CYCLES = 2700000,
    parameter int MAX_RETRIES    = 3,
    parameter int MRST_CYCLES    = 16
) (
    input  logic               clk,
    input  logic               reset,
    mouse_cursor_ctrl_if.slave bus
);

    typedef enum logic [2:0] {LINK_RST, WAIT_ACK, ACTIVE, BACKOFF, FAILED} state_t;

    localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - 1);

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  retry_q, retry_d;
    logic        mouse_reset_q, mouse_reset_d;
    logic        mouse_read_q, mouse_read_d;
    logic [9:0]  cursor_x_q, cursor_x_d;
    logic [9:0]  cursor_y_q, cursor_y_d;
    logic        btn_left_q, btn_left_d;
    logic        btn_right_q, btn_right_d;
    logic        draw_valid_q, draw_valid_d;
    logic        link_up_q, link_up_d;
    logic        link_fail_q, link_fail_d;

    logic signed [11:0] dx, dy, new_x, new_y;
    logic        [9:0]  clamp_x, clamp_y;

    function automatic logic [9:0] clamp_pos(input logic signed [11:0] v,
                                             input logic signed [11:0] hi);
        logic signed [11:0] r;
        r = v;
        if (v < 12'sd0) r = 12'sd0;
        else if (v > hi) r = hi;
        return r[9:0];
    endfunction

    // Screen Y grows downwards while mouse Y is positive-up, hence the subtraction.
    always_comb begin
        dx      = $signed({{3{bus.x_increment[8]}}, bus.x_increment}) >>> SENS_SHIFT;
        dy      = $signed({{3{bus.y_increment[8]}}, bus.y_increment}) >>> SENS_SHIFT;
        new_x   = $signed({2'b00, cursor_x_q}) + dx;
        new_y   = $signed({2'b00, cursor_y_q}) - dy;
        clamp_x = clamp_pos(new_x, X_MAX);
        clamp_y = clamp_pos(new_y, Y_MAX);
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        retry_d       = retry_q;
        mouse_reset_d = mouse_reset_q;
        mouse_read_d  = 1'b0;
        cursor_x_d    = cursor_x_q;
        cursor_y_d    = cursor_y_q;
        btn_left_d    = btn_left_q;
        btn_right_d   = btn_right_q;
        draw_valid_d  = 1'b0;
        link_up_d     = link_up_q;
        link_fail_d   = link_fail_q;

        case (state_q)
            LINK_RST: begin
                if (timer_q == 32'(MRST_CYCLES - 1)) begin
                    state_d       = WAIT_ACK;
                    timer_d       = '0;
                    mouse_reset_d = 1'b0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            WAIT_ACK: begin
                if (bus.error_no_ack) begin
                    state_d = BACKOFF;
                    timer_d = '0;
                    retry_d = retry_q + 8'd1;
                end else if (bus.data_ready || timer_q == 32'(ACK_TIMEOUT - 1)) begin
                    state_d   = ACTIVE;
                    timer_d   = '0;
                    retry_d   = '0;
                    link_up_d = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            ACTIVE: begin
                if (bus.error_no_ack) begin
                    state_d   = BACKOFF;
                    timer_d   = '0;
                    retry_d   = retry_q + 8'd1;
                    link_up_d = 1'b0;
                end else if (bus.data_ready && !mouse_read_q) begin
                    mouse_read_d = 1'b1;
                    cursor_x_d   = clamp_x;
                    cursor_y_d   = clamp_y;
                    btn_left_d   = bus.left_button;
                    btn_right_d  = bus.right_button;
                    draw_valid_d = bus.left_button &&
                                   (clamp_x != cursor_x_q || clamp_y != cursor_y_q);
                end
            end
            BACKOFF: begin
                if (retry_q == 8'(MAX_RETRIES)) begin
                    state_d       = FAILED;
                    mouse_reset_d = 1'b1;
                    link_fail_d   = 1'b1;
                end else if (timer_q == 32'(BACKOFF_CYCLES - 1)) begin
                    state_d       = LINK_RST;
                    timer_d       = '0;
                    mouse_reset_d = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            FAILED: begin
                // The cursor is deliberately left where it was across a rearm.
                if (bus.rearm) begin
                    state_d     = LINK_RST;
                    timer_d     = '0;
                    retry_d     = '0;
                    link_fail_d = 1'b0;
                end
            end
            default: begin
                state_d       = LINK_RST;
                timer_d       = '0;
                mouse_reset_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= LINK_RST;
            timer_q       <= '0;
            retry_q       <= '0;
            mouse_reset_q <= 1'b1;
            mouse_read_q  <= 1'b0;
            cursor_x_q    <= 10'(SCREEN_W / 2);
            cursor_y_q    <= 10'(SCREEN_H / 2);
            btn_left_q    <= 1'b0;
            btn_right_q   <= 1'b0;
            draw_valid_q  <= 1'b0;
            link_up_q     <= 1'b0;
            link_fail_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            mouse_reset_q <= mouse_reset_d;
            mouse_read_q  <= mouse_read_d;
            cursor_x_q    <= cursor_x_d;
            cursor_y_q    <= cursor_y_d;
            btn_left_q    <= btn_left_d;
            btn_right_q   <= btn_right_d;
            draw_valid_q  <= draw_valid_d;
            link_up_q     <= link_up_d;
            link_fail_q   <= link_fail_d;
        end
    end

    assign bus.mouse_reset = mouse_reset_q;
    assign bus.mouse_read  = mouse_read_q;
    assign bus.cursor_x    = cursor_x_q;
    assign bus.cursor_y    = cursor_y_q;
    assign bus.btn_left    = btn_left_q;
    assign bus.btn_right   = btn_right_q;
    assign bus.draw_valid  = draw_valid_q;
    assign bus.link_up     = link_up_q;
    assign bus.link_fail   = link_fail_q;

endmodule
